elastic_pipe: RTL and testbench
===============================

Name: elastic_pipe

Overview:
DEPTH-stage valid/ready register pipeline that carries WIDTH-bit words from a producer to a consumer. Each stage holds one word and updates on the clock edge, so all stages shift together without race hazards. Backpressure is supported, and a bubble in any stage is filled while later stages are stalled. It sits between a stimulus source and a checker, and is the reusable pipeline primitive for later datapath blocks.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of register stages (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all stages
in_valid  input  1  producer has a word on in_data
in_ready  output  1  pipeline accepts in_data this cycle
in_data  input  WIDTH  input word
out_valid  output  1  last stage holds a valid word
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  WIDTH  last stage word
occupancy  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset: the design has one clock, and reset is asynchronous and active-low. While rst_n=0, all stage valid bits are 0, all stage data registers are 0, out_valid=0, out_data=0 and occupancy=0. in_ready=0 while rst_n=0 and returns to 1 in the first cycle after deassertion.
- Stage i (0 = input side, DEPTH-1 = output side) holds v[i] and d[i].
- Ready chain (combinational): rdy[DEPTH-1] = !v[DEPTH-1] | out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready = rdy[0] & !flush & rst_n.
- Per edge, stage i loads from stage i-1 (stage 0 loads from the input) when rdy[i]=1. On load, v[i] takes the upstream valid and d[i] takes the upstream data only if the upstream valid is 1; otherwise d[i] holds.
- A stage with v=1 and rdy=0 holds its data unchanged. out_data must stay stable while out_valid & !out_ready.
- Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Latency: a word accepted at edge k appears with out_valid=1 after edge k+DEPTH-1, which is DEPTH cycles of register delay when there are no stalls.
- Throughput: 1 word/clock when out_ready stays 1. With DEPTH words held and out_ready=1, an input can be accepted in the same cycle as the output transfer.
- Bubble collapse: an empty stage upstream of a stalled full stage still accepts a word, so the pipeline can fill to DEPTH words under a full stall.
- Full: all v=1 and out_ready=0 give in_ready=0, and no state changes.
- Empty: all v=0 give out_valid=0 and occupancy=0. out_data shows the last value held.
- Flush: when flush=1, every v is cleared at the edge and d is left unchanged. Input is not accepted (in_ready=0), and any output transfer in that cycle still counts as consumed. flush has priority over all loads.
- Occupancy is registered and equals the population count of v after each edge: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither, 0 after flush. Range is 0..DEPTH with no wrap.
- Reset mid-operation: an asynchronous clear of all state. Words in flight are discarded and nothing is emitted afterwards.
- DEPTH=1: a single register. in_ready = !v0 | out_ready.

Decomposition:
- Shared package elastic_pkg holds the default WIDTH/DEPTH constants and a function occ_width(depth) = $clog2(depth+1).
- One sub-module, elastic_stage: a single valid/data register with an upstream/downstream ready, instantiated DEPTH times in a generate loop. The top level builds the ready chain and the occupancy counter.

Test Plan:
- Streaming: WIDTH=8, DEPTH=4, out_ready=1, inputs 0x01..0x10 on consecutive cycles -> 0x01 is out after 4 edges, then one word per cycle in order, and in_ready stays 1.
- Full stall: out_ready=0, send 0xA0..0xA5 -> 0xA0..0xA3 accepted, in_ready=0 after the 4th, occupancy=4, out_data=0xA0 stable. Then out_ready=1 -> the order is 0xA0,0xA1,0xA2,0xA3 then 0xA4,0xA5.
- Bubble fill: send 0x11, idle 2 cycles, send 0x22 with out_ready=0 -> both stored, occupancy=2. Release gives 0x11 then 0x22 on consecutive cycles.
- Simultaneous in/out when full: occupancy=4, in_valid=1, out_ready=1 -> one word in and one out in the same cycle, occupancy stays 4.
- Flush: occupancy=3, pulse flush with in_valid=1 -> in_ready=0 that cycle, then occupancy=0, out_valid=0, and the flushed words never appear.
- Reset mid-stream: rst_n low for 1 cycle while occupancy=2, asynchronously between edges -> outputs are 0 immediately. After release, in_ready=1 and the old data does not reappear.

Source files
------------

// File: rtl/elastic_pkg.sv
// Shared constants and helpers for the elastic valid/ready pipeline.
package elastic_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/elastic_stage.sv
// One valid/data register of the elastic pipeline; it is ready whenever it is
// empty or its downstream neighbour is ready.
module elastic_stage
   import elastic_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_up_valid,
   input  logic [WIDTH-1:0] i_up_data,
   input  logic             i_dn_ready,
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   assign o_ready = !r_valid | i_dn_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   // Data only moves with a valid word, so an empty stage keeps showing its last word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (o_ready) begin
         r_valid <= i_up_valid;
         if (i_up_valid) r_data <= i_up_data;
      end
   end

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse, flush and a
// registered occupancy count.
module elastic_pipe
   import elastic_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [occ_width(DEPTH)-1:0]  occupancy
);

   localparam int OCC_W = occ_width(DEPTH);

   logic             w_valid [DEPTH];
   logic [WIDTH-1:0] w_data  [DEPTH];
   logic             w_rdy   [DEPTH+1];
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic [OCC_W-1:0] r_occ;

   assign w_rdy[DEPTH] = out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             w_up_valid;
      logic [WIDTH-1:0] w_up_data;

      if (i == 0) begin : g_head
         assign w_up_valid = in_valid;
         assign w_up_data  = in_data;
      end else begin : g_body
         assign w_up_valid = w_valid[i-1];
         assign w_up_data  = w_data[i-1];
      end

      elastic_stage #(.WIDTH(WIDTH)) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_flush    (flush),
         .i_up_valid (w_up_valid),
         .i_up_data  (w_up_data),
         .i_dn_ready (w_rdy[i+1]),
         .o_ready    (w_rdy[i]),
         .o_valid    (w_valid[i]),
         .o_data     (w_data[i])
      );
   end

   assign in_ready   = w_rdy[0] & !flush & rst_n;
   assign out_valid  = w_valid[DEPTH-1];
   assign out_data   = w_data[DEPTH-1];
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;

   // Stages shift without creating or losing words, so the population only
   // changes by the boundary transfers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ <= '0;
      end else if (flush) begin
         r_occ <= '0;
      end else if (w_in_xfer && !w_out_xfer) begin
         r_occ <= r_occ + OCC_W'(1);
      end else if (!w_in_xfer && w_out_xfer) begin
         r_occ <= r_occ - OCC_W'(1);
      end
   end

   assign occupancy = r_occ;

endmodule

// File: tb/tb_elastic_pipe.sv
// Self-checking bench for elastic_pipe: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_elastic_pipe;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic [2:0]   occupancy;

   elastic_pipe #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: in-flight words, oldest first, with their stage index.
   typedef struct {
      int           p;
      logic [W-1:0] d;
   } ent_t;
   ent_t         mq[$];
   logic [W-1:0] m_dout = '0;

   logic         s_ir, s_ov;
   logic [W-1:0] s_od;
   int           s_occ;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_in_ready(input logic fl, input logic ordy);
      return !fl && ((mq.size() < D) || ordy);
   endfunction

   function automatic bit m_out_valid();
      return (mq.size() > 0) && (mq[0].p == D-1);
   endfunction

   // A word advances when the consumer takes or a hole exists downstream of it.
   task automatic m_step(input logic fl, input logic iv, input logic [W-1:0] id, input logic ordy);
      bit took_in, took_out;
      if (fl) begin
         mq.delete();
         return;
      end
      took_in  = iv && ((mq.size() < D) || ordy);
      took_out = ordy && m_out_valid();
      for (int k = 0; k < mq.size(); k++)
         if (ordy || (k < D-1-mq[k].p)) mq[k].p++;
      if (took_out) void'(mq.pop_front());
      if (took_in) mq.push_back('{0, id});
      if (m_out_valid()) m_dout = mq[0].d;
   endtask

   task automatic m_reset();
      mq.delete();
      m_dout = '0;
   endtask

   task automatic cyc(input logic fl, input logic iv, input logic [W-1:0] id, input logic ordy);
      @(negedge clk);
      flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
      #1;
      s_ir = in_ready; s_ov = out_valid; s_od = out_data; s_occ = int'(occupancy);
      chk("model_in_ready", s_ir, m_in_ready(fl, ordy));
      chk("model_out_valid", s_ov, m_out_valid());
      chk("model_out_data", s_od, m_dout);
      chk("model_occupancy", s_occ, mq.size());
      @(posedge clk);
      m_step(fl, iv, id, ordy);
   endtask

   typedef struct {
      logic         fl, iv;
      logic [W-1:0] id;
      logic         ordy;
      logic         e_ir, e_ov;
      logic [W-1:0] e_od;
      int           e_occ;
   } vec_t;
   vec_t tbl[13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Full stall, simultaneous in/out when full, drain to empty.
      tbl[0]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00, 0};
      tbl[1]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 1};
      tbl[2]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00, 2};
      tbl[3]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'h00, 3};
      tbl[4]  = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
      tbl[5]  = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
      tbl[6]  = '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA0, 4};
      tbl[7]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA1, 4};
      tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 4};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 3};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 2};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1};
      tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 0};

      #12;
      chk("reset_in_ready", in_ready, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_occupancy", occupancy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();

      for (int i = 0; i < 13; i++) begin
         cyc(tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
         chk($sformatf("tbl%0d_in_ready", i), s_ir, tbl[i].e_ir);
         chk($sformatf("tbl%0d_out_valid", i), s_ov, tbl[i].e_ov);
         chk($sformatf("tbl%0d_out_data", i), s_od, tbl[i].e_od);
         chk($sformatf("tbl%0d_occupancy", i), s_occ, tbl[i].e_occ);
      end

      // Streaming 0x01..0x10: first word out after 4 edges, then one per cycle.
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, i < 16, W'(i + 1), 1'b1);
         chk("stream_in_ready", s_ir, 1);
         chk("stream_out_valid", s_ov, i >= 4);
         if (i >= 4) chk("stream_out_data", s_od, i - 3);
      end

      // Bubble fill under a full stall.
      cyc(1'b0, 1'b1, 8'h11, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, 8'h22, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("bubble_occupancy", s_occ, 2);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("bubble_stall_data", s_od, 8'h11);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("bubble_first", s_od, 8'h11);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("bubble_second_valid", s_ov, 1);
      chk("bubble_second", s_od, 8'h22);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("bubble_drained", s_ov, 0);

      // Flush with three words held.
      cyc(1'b0, 1'b1, 8'h31, 1'b0);
      cyc(1'b0, 1'b1, 8'h32, 1'b0);
      cyc(1'b0, 1'b1, 8'h33, 1'b0);
      cyc(1'b1, 1'b1, 8'h34, 1'b0);
      chk("flush_in_ready", s_ir, 0);
      chk("flush_pre_occ", s_occ, 3);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b0, 8'h00, 1'b1);
         chk("flush_out_valid", s_ov, 0);
         chk("flush_occupancy", s_occ, 0);
      end

      // Asynchronous reset between edges with two words in flight.
      cyc(1'b0, 1'b1, 8'h41, 1'b0);
      cyc(1'b0, 1'b1, 8'h42, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_data", out_data, 0);
      chk("arst_occupancy", occupancy, 0);
      chk("arst_in_ready", in_ready, 0);
      m_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b0, 8'h00, 1'b1);
         chk("arst_after_in_ready", s_ir, 1);
         chk("arst_after_out_valid", s_ov, 0);
      end

      // Randomized traffic with stall-heavy and stream-heavy phases.
      for (int j = 0; j < 3000; j++) begin
         logic fl, iv, ordy;
         fl   = ($urandom_range(0, 63) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ((j / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                     : ($urandom_range(0, 3) == 0);
         cyc(fl, iv, W'($urandom), ordy);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
